// File: rtl/vga_pkg.sv
// Shared 640x480@60 receive timing constants, FSM state type and CRC-16-CCITT helpers
// for the VGA receiver slice.
package vga_pkg;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_H_START  = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_START  = 33;
  localparam int VGA_V_ACTIVE = 480;

  localparam logic [10:0] CNT_MAX  = 11'd2047;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

  // One 24-bit step of CRC-16-CCITT, data consumed MSB first.
  function automatic logic [15:0] crc16_step24(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      if (fb) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// Per-frame CRC-16-CCITT accumulator over 24-bit pixels; present only when VGA_RX_CRC_EN is defined.
`ifdef VGA_RX_CRC_EN
module vga_rx_crc16
  import vga_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        frame_end,
  input  logic        publish,
  input  logic        data_valid,
  input  logic [23:0] data,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  logic [15:0] crc_r;

  // Accumulate pixels; at each frame boundary optionally publish, then re-init.
  always_ff @(posedge clock) begin
    if (rst) begin
      crc_r     <= CRC_INIT;
      frame_crc <= 16'h0000;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= frame_end && publish;
      if (frame_end) begin
        crc_r <= CRC_INIT;
        if (publish) begin
          frame_crc <= crc_r;
        end
      end else if (data_valid) begin
        crc_r <= crc16_step24(crc_r, data);
      end
    end
  end

endmodule
`endif

// File: rtl/vga_receiver.sv
// VGA timing sink: recovers pixel coordinates, measures line/frame periods and locks.
// Optional per-frame CRC output enabled by macro VGA_RX_CRC_EN.
module vga_receiver
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int H_START  = VGA_H_START,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_START  = VGA_V_START,
  parameter int V_ACTIVE = VGA_V_ACTIVE
)(
  input  logic        clock,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] h_period,
  output logic [10:0] v_period
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] H_START_C = 11'(H_START);
  localparam logic [10:0] H_END_C   = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_START_C = 11'(V_START);
  localparam logic [10:0] V_END_C   = 11'(V_START + V_ACTIVE);

  logic        hsync_q_r, vsync_q_r;
  logic        h_rise_s, v_rise_s;
  logic [10:0] h_cnt_r, v_cnt_r, h_cnt_nxt_s, v_cnt_nxt_s, h_meas_s, v_meas_s;
  logic        h_bad_s, v_bad_s, line_bad_r;
  vga_state_e  state_r, state_nxt_s;
  logic        timing_err_s, frame_start_s, valid_nxt_s;
  logic [9:0]  x_off_s, y_off_s;

  // Edge detect, saturating counters and period measurements (saturated, so no wrap to 0).
  always_comb begin
    h_rise_s = !hsync_q_r && hsync;
    v_rise_s = !vsync_q_r && vsync;
    h_meas_s = (h_cnt_r == CNT_MAX) ? CNT_MAX : h_cnt_r + 11'd1;
    v_meas_s = (v_cnt_r == CNT_MAX) ? CNT_MAX : v_cnt_r + 11'd1;
    h_cnt_nxt_s = h_rise_s ? 11'd0 : h_meas_s;
    if (v_rise_s) begin
      v_cnt_nxt_s = 11'd0;
    end else if (h_rise_s) begin
      v_cnt_nxt_s = v_meas_s;
    end else begin
      v_cnt_nxt_s = v_cnt_r;
    end
    h_bad_s = h_rise_s && (h_meas_s != H_TOTAL_C);
    v_bad_s = v_rise_s && (v_meas_s != V_TOTAL_C);
  end

  // Lock FSM next state; a bad line ending on the vsync-rise cycle still spoils the frame.
  always_comb begin
    state_nxt_s  = state_r;
    timing_err_s = 1'b0;
    case (state_r)
      SEARCH: begin
        if (v_rise_s) state_nxt_s = MEASURE;
        else          state_nxt_s = SEARCH;
      end
      MEASURE: begin
        if (v_rise_s && !line_bad_r && !h_bad_s && !v_bad_s) state_nxt_s = LOCKED;
        else                                                 state_nxt_s = MEASURE;
      end
      LOCKED: begin
        if (h_bad_s || v_bad_s) begin
          state_nxt_s  = MEASURE;
          timing_err_s = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = SEARCH;
    endcase
    frame_start_s = v_rise_s && (state_nxt_s == LOCKED);
  end

  // Active-window decode on the post-update counters.
  always_comb begin
    valid_nxt_s = (state_nxt_s == LOCKED) &&
                  (h_cnt_nxt_s >= H_START_C) && (h_cnt_nxt_s < H_END_C) &&
                  (v_cnt_nxt_s >= V_START_C) && (v_cnt_nxt_s < V_END_C);
    x_off_s = 10'(h_cnt_nxt_s - H_START_C);
    y_off_s = 10'(v_cnt_nxt_s - V_START_C);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      hsync_q_r   <= 1'b1;
      vsync_q_r   <= 1'b1;
      h_cnt_r     <= 11'd0;
      v_cnt_r     <= 11'd0;
      line_bad_r  <= 1'b0;
      state_r     <= SEARCH;
      h_period    <= 11'd0;
      v_period    <= 11'd0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
    end else begin
      hsync_q_r <= hsync;
      vsync_q_r <= vsync;
      h_cnt_r   <= h_cnt_nxt_s;
      v_cnt_r   <= v_cnt_nxt_s;
      if (h_rise_s) h_period <= h_meas_s;
      if (v_rise_s) v_period <= v_meas_s;
      if (v_rise_s)     line_bad_r <= 1'b0;
      else if (h_bad_s) line_bad_r <= 1'b1;
      state_r     <= state_nxt_s;
      locked      <= (state_nxt_s == LOCKED);
      timing_err  <= timing_err_s;
      frame_start <= frame_start_s;
      pix_valid   <= valid_nxt_s;
      pix_x       <= valid_nxt_s ? x_off_s : 10'd0;
      pix_y       <= valid_nxt_s ? y_off_s : 10'd0;
      pix_r       <= r_in;
      pix_g       <= g_in;
      pix_b       <= b_in;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic crc_publish_s;
  // Only frames that began while already locked are published.
  assign crc_publish_s = frame_start_s && (state_r == LOCKED);

  vga_rx_crc16 u_crc (
    .clock      (clock),
    .rst        (rst),
    .frame_end  (v_rise_s),
    .publish    (crc_publish_s),
    .data_valid (valid_nxt_s),
    .data       ({r_in, g_in, b_in}),
    .frame_crc  (frame_crc),
    .crc_valid  (crc_valid)
  );
`endif

endmodule
